// File: rtl/traffic_request_gen.sv
// traffic_request_gen
// Request-side front end for the intersection light controller. Each raw
// vehicle sensor is synchronised and debounced. A rising filtered value
// raises a pending request and an immediate one-cycle pulse. The request is
// re-pulsed every RETRY cycles until the light feedback shows that direction
// green. Coincident pulses are arbitrated by a rotating priority token, and a
// starvation flag is raised when a pending request has waited STARVE cycles.
module traffic_request_gen #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned RETRY    = 8,
    parameter int unsigned STARVE   = 64,
    parameter logic [1:0]  GREEN_N  = 2'b01,
    parameter logic [1:0]  GREEN_W  = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_n,
    input  logic       sensor_w,
    input  logic [1:0] light,
    output logic       n,
    output logic       w,
    output logic       pend_n,
    output logic       pend_w,
    output logic       starve
);

    // Counter widths: the debounce counter can represent DEBOUNCE, the retry
    // timer holds RETRY-1, and the wait counter saturates at STARVE.
    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned RT_W = $clog2(RETRY);
    localparam int unsigned WT_W = $clog2(STARVE + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RETRY - 1);
    localparam logic [WT_W-1:0] WT_MAX  = WT_W'(STARVE);

    // Index of each direction in the per-direction vectors and arrays.
    localparam int DIR_N = 0;
    localparam int DIR_W = 1;

    // Priority token: which direction wins when both pulses fall due together.
    typedef enum logic {
        TOK_N = 1'b0,
        TOK_W = 1'b1
    } tok_e;

    // Synchroniser and debounce state.
    logic [1:0]      raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic [1:0]      filt_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    // Request tracking state.
    logic [1:0]      served;
    logic [1:0]      arrival;
    logic [1:0]      req;
    logic [1:0]      grant;
    logic [1:0]      pend_q;
    logic [1:0]      pend_d;
    logic [1:0]      pulse_q;
    logic [RT_W-1:0] retry_q [2];
    logic [RT_W-1:0] retry_d [2];
    logic [WT_W-1:0] wait_q  [2];
    logic [WT_W-1:0] wait_d  [2];
    tok_e            tok_q;
    tok_e            tok_d;
    logic            starve_q;
    logic            starve_d;

    assign raw = {sensor_w, sensor_n};

    // Debounce: count cycles of disagreement, toggle the filtered value once
    // the synchronised sensor has disagreed for DEBOUNCE consecutive cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]   = filt_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    filt_d[i] = ~filt_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pulse requests and arbitration. A direction wants a pulse on a new
    // arrival or when its retry timer has run out, unless it is green now.
    // The collision loser keeps its timer at zero (or its arrival marker), so
    // it is still due next cycle, and the flipped token then favours it.
    always_comb begin
        served[DIR_N] = (light == GREEN_N);
        served[DIR_W] = (light == GREEN_W);
        arrival       = filt_q & ~filt_prev_q;
        for (int i = 0; i < 2; i++) begin
            req[i] = ~served[i] & (arrival[i] | (pend_q[i] & (retry_q[i] == '0)));
        end
        grant = req;
        tok_d = tok_q;
        if (&req) begin
            if (tok_q == TOK_N) begin
                grant[DIR_W] = 1'b0;
                tok_d        = TOK_W;
            end else begin
                grant[DIR_N] = 1'b0;
                tok_d        = TOK_N;
            end
        end
    end

    // Pending flag, retry timer and wait counter per direction. Service wins
    // over everything; an arrival that loses arbitration forces the timer to
    // zero so the pulse is still owed next cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pend_d[i]  = pend_q[i];
            retry_d[i] = retry_q[i];
            wait_d[i]  = wait_q[i];
            if (served[i]) begin
                pend_d[i]  = 1'b0;
                retry_d[i] = '0;
                wait_d[i]  = '0;
            end else begin
                if (arrival[i]) begin
                    pend_d[i] = 1'b1;
                end
                if (grant[i]) begin
                    retry_d[i] = RT_LOAD;
                end else if (arrival[i]) begin
                    retry_d[i] = '0;
                end else if (pend_q[i] && (retry_q[i] != '0)) begin
                    retry_d[i] = retry_q[i] - 1'b1;
                end
                if (pend_q[i] && (wait_q[i] < WT_MAX)) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
            end
        end
        starve_d = (wait_d[DIR_N] >= WT_MAX) | (wait_d[DIR_W] >= WT_MAX);
    end

    // State and registered outputs; reset clears everything, including the
    // synchronisers, so a held sensor re-arrives with full latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            pend_q      <= '0;
            pulse_q     <= '0;
            tok_q       <= TOK_N;
            starve_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
                retry_q[i]  <= '0;
                wait_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            pend_q      <= pend_d;
            pulse_q     <= grant;
            tok_q       <= tok_d;
            starve_q    <= starve_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                retry_q[i]  <= retry_d[i];
                wait_q[i]   <= wait_d[i];
            end
        end
    end

    assign n      = pulse_q[DIR_N];
    assign w      = pulse_q[DIR_W];
    assign pend_n = pend_q[DIR_N];
    assign pend_w = pend_q[DIR_W];
    assign starve = starve_q;

endmodule

// File: doc/traffic_request_gen.md
# traffic_request_gen

Request-side front end for the intersection light controller. It conditions the raw north and west vehicle sensors with synchronisation and debounce, and turns each new vehicle arrival into single-cycle `n`/`w` request pulses for the light FSM. It keeps a request pending and re-pulses it until the controller's `light` output shows that direction served. It also flags starvation when a request has waited too long.

## Interface
- `DEBOUNCE`, default 4: consecutive stable cycles required before the filtered sensor changes (≥1).
- `RETRY`, default 8: cycles between repeated pulses for an unserved pending request (≥2).
- `STARVE`, default 64: wait cycles at which `starve` asserts (≥1).
- `GREEN_N`, default 2'b01: `light` encoding meaning north green.
- `GREEN_W`, default 2'b10: `light` encoding meaning west green.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `sensor_n` in 1: raw north vehicle sensor, asynchronous to `clk`.
- `sensor_w` in 1: raw west vehicle sensor, asynchronous to `clk`.
- `light` in 2: current light state, fed back from the controller.
- `n` out 1: north request pulse, registered, one cycle wide.
- `w` out 1: west request pulse, registered, one cycle wide.
- `pend_n` out 1: north request outstanding.
- `pend_w` out 1: west request outstanding.
- `starve` out 1: some pending request has waited `STARVE` or more cycles.

## Operation
- **Per direction, the pipeline is:**
  - 2-flop synchroniser.
  - Debounce counter (width from `$clog2(DEBOUNCE+1)`): counts while the synchroniser output differs from the filtered value, clears on agreement. At `DEBOUNCE` the filtered value toggles and the counter clears.
- **Arrival:** a rising edge of the filtered value sets `pend_x`. It also schedules an immediate pulse.
- **Served:** `light == GREEN_x` sampled on an edge clears `pend_x`, the retry timer and the wait counter at that edge.
  - `x` never pulses in a cycle where `light == GREEN_x`.
  - An arrival while already green is dropped, because the direction is already being served.
- **Retry:** a down-counter loads `RETRY-1` on each pulse. It decrements while `pend_x` is high and not served. At 0 it requests another pulse.
- **Collision:** if the `n` and `w` pulses fall due in the same cycle, only the direction holding the priority token pulses.
  - The other direction pulses the following cycle.
  - The token flips after every collision. Its reset value is north.
  - `n` and `w` are never high together.
- **Wait counter:** increments each cycle `pend_x` is high, saturates at `STARVE`, clears on served. `starve` = (wait_n ≥ STARVE) OR (wait_w ≥ STARVE), registered.
- **Falling filtered sensor:** ignored; the pending request remains until served.
- **Light encodings:** 2'b00 (all red) and 2'b11 serve nobody.
- **Reset values:** `n`=0, `w`=0, `pend_n`=0, `pend_w`=0, `starve`=0. Filtered values are 0, all counters are 0, and the token is north.
- **Reset mid-operation:** pending requests are discarded. A sensor held high through reset re-arrives after the full sync + debounce latency.

## Timing
- **Arrival latency:** with the sensor stable high from edge 0:
  - The synchroniser output is high after edge 2.
  - The filtered value rises at edge 2+`DEBOUNCE`.
  - `pend_x` and `x` are high after edge 3+`DEBOUNCE` (7 with defaults).
- **Retry spacing:** subsequent pulses are `RETRY` cycles apart, plus 1 if deferred by a collision. A deferral does not shift later pulses of the other direction.
- **Served to clear:** 1 edge; `pend_x` is low the cycle after `light` shows green.
- **Glitches:** a sensor pulse shorter than `DEBOUNCE` cycles after synchronisation produces no request.

## Test plan
- **North arrival and service:**
  - Stimulus: `sensor_n` high for 10 cycles, `light`=00.
  - Required: `n` pulses 7 cycles after the rise, then at +8 and +16.
  - Stimulus: `light`=01.
  - Required: `pend_n` clears next edge and no further `n` pulses occur.
- **Glitch rejection:**
  - Stimulus: `sensor_w` high for 3 cycles.
  - Required: no `w`, `pend_w` stays 0.
- **Simultaneous arrival:**
  - Stimulus: both sensors rise in the same cycle.
  - Required: `n` pulses at cycle 7, `w` at cycle 8. At the next coincident retry, `w` goes first and `n` follows one cycle later.
- **Serve blocking:**
  - Stimulus: `light`=10 held while a west arrival occurs.
  - Required: no `w` pulse and `pend_w` stays 0. A north arrival in the same window still pulses `n`.
- **Starvation:**
  - Stimulus: north pending with `light`=10 for 70 cycles.
  - Required: `starve` rises 64 cycles after `pend_n` and falls one cycle after `light`=01.
- **Reset mid-operation:**
  - Stimulus: assert `reset` for 1 cycle with `pend_n`=1 and `sensor_n` held high.
  - Required: all outputs are 0 the next cycle, and `n` re-pulses 7 cycles after `reset` deasserts.
